// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses a framed byte stream, writes words into
// instruction memory, and releases the processor once the checksum verifies.
module imem_loader #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_CNT_HI = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

  logic [2:0]  state;
  logic [7:0]  cnt_hi;
  logic [15:0] word_cnt;
  logic [15:0] index;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic [7:0]  acc;

  logic        accept;
  logic [15:0] count_now;
  logic [15:0] index_next;
  logic        oversize;

  // Ready is gated by rst so it reads low for the whole reset pulse.
  assign byte_ready = !rst && (state == S_CNT_HI || state == S_CNT_LO ||
                               state == S_DATA   || state == S_CSUM);
  assign accept     = byte_valid && byte_ready;
  assign count_now  = {cnt_hi, byte_data};
  assign oversize   = {1'b0, count_now} > MAX_WORDS;
  assign index_next = index + 16'd1;
  assign load_done  = cpu_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CNT_HI;
      cnt_hi     <= 8'd0;
      word_cnt   <= 16'd0;
      index      <= 16'd0;
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      acc        <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= 32'd0;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_CNT_HI: begin
            cnt_hi <= byte_data;
            state  <= S_CNT_LO;
          end
          S_CNT_LO: begin
            word_cnt <= count_now;
            if (oversize) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else if (count_now == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            acc      <= acc ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            // The fourth byte completes the word; the write is registered so
            // address and data are stable for the whole strobe cycle.
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {partial, byte_data};
              imem_addr  <= ADDR_BASE + {14'd0, index, 2'b00};
              index      <= index_next;
              if (index_next == word_cnt) state <= S_CSUM;
            end else begin
              partial <= {partial[15:0], byte_data};
            end
          end
          S_CSUM: begin
            if (byte_data == acc) begin
              state   <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame-level model predicts writes and the
// final verdict, and a negedge monitor checks every write strobe against it.
module tb_imem_loader;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_BASE(ADDR_BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: decodes the byte list by the framing rules, pushes
  // every complete word it implies, and reports how many bytes are consumed.
  // outcome: 0 = frame incomplete, 1 = loaded, 2 = rejected.
  task automatic modelFrame(input bq_t b, output int outcome, output int consumed);
    int n;
    logic [7:0] x;
    outcome  = 0;
    consumed = b.size();
    x = 8'd0;
    if (b.size() >= 2) begin
      n = {b[0], b[1]};
      if (n > MEM_WORDS) begin
        outcome  = 2;
        consumed = 2;
      end else begin
        for (int w = 0; w < n; w++) begin
          if (b.size() >= 2 + 4 * (w + 1)) begin
            exp_addr_q.push_back(ADDR_BASE + 32'(4 * w));
            exp_data_q.push_back({b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
            x = x ^ b[2+4*w] ^ b[3+4*w] ^ b[4+4*w] ^ b[5+4*w];
          end
        end
        if (b.size() > 2 + 4 * n) begin
          consumed = 3 + 4 * n;
          outcome  = (b[2+4*n] == x) ? 1 : 2;
        end
      end
    end
  endtask

  // Drives bytes starting at posedge+1, with random idle gaps between them.
  task automatic applyStimulus(input bq_t b, input int gap_max, input bit in_frame);
    foreach (b[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b[i];
      checkOutput(in_frame ? "ready_in_frame" : "ready_after_end", byte_ready, in_frame);
      if (in_frame) checkOutput("early_result", {cpu_run, load_err}, 2'b00);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic resetDut();
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_we",    imem_we,    0);
    checkOutput("rst_addr",  imem_addr,  ADDR_BASE);
    checkOutput("rst_wdata", imem_wdata, 0);
    checkOutput("rst_run",   cpu_run,    0);
    checkOutput("rst_done",  load_done,  0);
    checkOutput("rst_err",   load_err,   0);
    checkOutput("rst_ready", byte_ready, 0);
    checkOutput("rst_pending_writes", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutput("ready_after_rst", byte_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic runFrame(input bq_t b, input int gap_max, input bit do_reset);
    int outcome, consumed;
    bq_t head, tail;
    if (do_reset) resetDut();
    modelFrame(b, outcome, consumed);
    foreach (b[i]) begin
      if (i < consumed) head.push_back(b[i]);
      else              tail.push_back(b[i]);
    end
    applyStimulus(head, gap_max, 1'b1);
    if (outcome != 0) begin
      checkOutput("cpu_run",    cpu_run,    outcome == 1);
      checkOutput("load_done",  load_done,  outcome == 1);
      checkOutput("load_err",   load_err,   outcome == 2);
      checkOutput("ready_term", byte_ready, 0);
    end
    applyStimulus(tail, gap_max, 1'b0);
    repeat (3) @(posedge clk);
    #1 checkOutput("pending_writes", exp_addr_q.size(), 0);
  endtask

  task automatic runRandom(input int n, input bit corrupt);
    bq_t b;
    logic [7:0] x, r;
    x = 8'd0;
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      r = 8'($urandom);
      b.push_back(r);
      x ^= r;
    end
    b.push_back(corrupt ? x ^ 8'($urandom_range(1, 255)) : x);
    repeat ($urandom_range(0, 2)) b.push_back(8'($urandom));
    runFrame(b, $urandom_range(0, 3), 1'b1);
  endtask

  // Monitor: every strobe must match the oldest predicted write and be one cycle wide.
  bit prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        checkOutput("we_width", prev_we, 0);
        checkOutput("we_with_run", cpu_run, 0);
        if (exp_addr_q.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
        end else begin
          checkOutput("write_addr", imem_addr,  exp_addr_q.pop_front());
          checkOutput("write_data", imem_wdata, exp_data_q.pop_front());
        end
      end
      checkOutput("run_err_exclusive", cpu_run & load_err, 0);
    end
    prev_we = rst ? 1'b0 : imem_we;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int outcome, consumed;
    rst        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(posedge clk); #1;

    $display("[TB] good image");
    runFrame('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E}, 0, 1'b1);
    $display("[TB] bad checksum with trailing bytes");
    runFrame('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F,
               8'h11, 8'h22, 8'h33, 8'h44}, 0, 1'b1);
    $display("[TB] empty image");
    runFrame('{8'h00, 8'h00, 8'h00}, 0, 1'b1);
    $display("[TB] oversize image");
    runFrame('{8'h00, 8'h41, 8'h20, 8'h08, 8'h00, 8'h05}, 0, 1'b1);
    $display("[TB] gapped good image");
    for (int k = 0; k < 3; k++)
      runFrame('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E}, 3, 1'b1);

    $display("[TB] reset mid-word");
    resetDut();
    modelFrame('{8'h00, 8'h01, 8'h12, 8'h34}, outcome, consumed);
    applyStimulus('{8'h00, 8'h01, 8'h12, 8'h34}, 0, 1'b1);
    resetDut();
    runFrame('{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h88}, 0, 1'b0);

    $display("[TB] reset after writes, before checksum check");
    resetDut();
    modelFrame('{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99},
               outcome, consumed);
    applyStimulus('{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99},
                  0, 1'b1);
    resetDut();
    runFrame('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 0, 1'b0);

    $display("[TB] boundary sizes");
    runRandom(MEM_WORDS, 1'b0);
    runRandom(MEM_WORDS + 1, 1'b0);
    runRandom(1, 1'b1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 16; k++)
      runRandom($urandom_range(0, 6), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
